vga_rx_monitor: RTL and testbench

Receive-side companion to the maze VGA generator. It samples the generator's VGA_CLK, VGA_HS, VGA_VS and RGB outputs in the CLOCK_50 domain and checks the sync timing against the fixed raster (800 ticks per line, 525 lines per frame). Once locked, it recovers raw raster coordinates and a per-pixel strobe with captured colour. It serves as an on-chip self-check and as the capture front end for frame-grab and debug logic.

---
 rtl/vga_rx_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_rx_monitor
// Purpose  : Samples a VGA_CLK/HS/VS/RGB stream in the CLOCK_50 domain, checks
//            sync timing against a fixed raster, locks, and recovers pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_rx_monitor #(
  parameter int H_TOTAL   = 800,
  parameter int HS_WIDTH  = 97,
  parameter int V_TOTAL   = 525,
  parameter int VS_WIDTH  = 3,
  parameter int H_ACT_MIN = 97,
  parameter int V_ACT_MIN = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic [7:0]  err_count,
  output logic [1:0]  err_code
);

  localparam logic [9:0] C_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_HS_W    = 10'(HS_WIDTH);
  localparam logic [9:0] C_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_VS_W    = 10'(VS_WIDTH);
  localparam logic [9:0] C_H_ACT   = 10'(H_ACT_MIN);
  localparam logic [9:0] C_V_ACT   = 10'(V_ACT_MIN);
  localparam logic [9:0] C_CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_clk_q;
  logic        r_s_stb;
  logic        r_s_hs;
  logic        r_s_vs;
  logic [23:0] r_s_rgb;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [9:0]  r_hs_cnt;
  logic [9:0]  r_vs_cnt;

  logic        w_tick;
  logic        w_hs_rise;
  logic        w_hs_fall;
  logic        w_vs_rise;
  logic        w_vs_fall;
  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic [9:0]  w_hs_cnt_nxt;
  logic [9:0]  w_vs_cnt_nxt;
  logic        w_e0;
  logic        w_e1;
  logic        w_e2;
  logic        w_e3;
  logic        w_err;
  logic [1:0]  w_code;
  logic        w_pix;
  logic        w_fs;

  assign w_tick = vga_clk & ~r_clk_q;
  assign locked = (r_state == ST_LOCKED);

  always_comb begin
    w_hs_rise    = r_s_hs & ~r_hs_prev;
    w_hs_fall    = ~r_s_hs & r_hs_prev;
    w_vs_rise    = r_s_vs & ~r_vs_prev;
    w_vs_fall    = ~r_s_vs & r_vs_prev;
    w_h_nxt      = r_h;
    w_v_nxt      = r_v;
    w_hs_cnt_nxt = r_hs_cnt;
    w_vs_cnt_nxt = w_vs_rise ? 10'd0 : r_vs_cnt;
    w_state_nxt  = r_state;
    w_code       = 2'd0;

    if (w_hs_rise) begin
      w_h_nxt      = 10'd0;
      w_hs_cnt_nxt = 10'd1;
      if (w_vs_rise)
        w_v_nxt = 10'd0;
      else if (r_v != C_CNT_MAX)
        w_v_nxt = r_v + 10'd1;
      if (r_s_vs && (w_vs_cnt_nxt != C_CNT_MAX))
        w_vs_cnt_nxt = w_vs_cnt_nxt + 10'd1;
    end else begin
      if (r_h != C_CNT_MAX)
        w_h_nxt = r_h + 10'd1;
      if (r_s_hs && (r_hs_cnt != C_CNT_MAX))
        w_hs_cnt_nxt = r_hs_cnt + 10'd1;
    end

    // The 1022->1023 step flags an overlong line exactly once per saturation.
    w_e0  = w_hs_rise ? (r_h != C_H_LAST) : (r_h == C_CNT_MAX - 10'd1);
    w_e1  = w_hs_fall && (r_hs_cnt != C_HS_W);
    w_e2  = w_vs_rise && (r_v != C_V_LAST);
    w_e3  = w_vs_fall && (r_vs_cnt != C_VS_W);
    w_err = r_s_stb && (r_state != ST_SEARCH) && (w_e0 || w_e1 || w_e2 || w_e3);

    if (w_e3)      w_code = 2'd3;
    else if (w_e2) w_code = 2'd2;
    else if (w_e1) w_code = 2'd1;

    if (r_s_stb) begin
      case (r_state)
        ST_SEARCH: if (w_vs_rise) w_state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (w_err)          w_state_nxt = ST_SEARCH;
          else if (w_vs_rise) w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: if (w_err) w_state_nxt = ST_SEARCH;
        default:   w_state_nxt = ST_SEARCH;
      endcase
    end

    w_fs  = r_s_stb && w_vs_rise && (w_state_nxt == ST_LOCKED);
    w_pix = r_s_stb && (w_state_nxt == ST_LOCKED) &&
            (w_h_nxt >= C_H_ACT) && (w_v_nxt >= C_V_ACT);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= ST_SEARCH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_clk_q     <= 1'b0;
      r_s_stb     <= 1'b0;
      r_s_hs      <= 1'b0;
      r_s_vs      <= 1'b0;
      r_s_rgb     <= 24'd0;
      r_hs_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_h         <= 10'd0;
      r_v         <= 10'd0;
      r_hs_cnt    <= 10'd0;
      r_vs_cnt    <= 10'd0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 24'd0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
      err_count   <= 8'd0;
      err_code    <= 2'd0;
    end else begin
      r_clk_q     <= vga_clk;
      r_s_stb     <= w_tick;
      pix_valid   <= w_pix;
      frame_start <= w_fs;
      if (w_tick) begin
        r_s_hs  <= vga_hs;
        r_s_vs  <= vga_vs;
        r_s_rgb <= {vga_r, vga_g, vga_b};
      end
      if (r_s_stb) begin
        r_hs_prev <= r_s_hs;
        r_vs_prev <= r_s_vs;
        r_h       <= w_h_nxt;
        r_v       <= w_v_nxt;
        r_hs_cnt  <= w_hs_cnt_nxt;
        r_vs_cnt  <= w_vs_cnt_nxt;
      end
      if (w_pix) begin
        pix_x   <= w_h_nxt;
        pix_y   <= w_v_nxt;
        pix_rgb <= r_s_rgb;
      end
      if (w_fs)
        frame_count <= frame_count + 8'd1;
      if (w_err) begin
        err_code <= w_code;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_rx_monitor
// Purpose  : Scoreboard bench for vga_rx_monitor on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_rx_monitor;

  localparam int H   = 40;
  localparam int HSW = 4;
  localparam int V   = 16;
  localparam int VSW = 3;
  localparam int HA  = 6;
  localparam int VA  = 3;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        vga_clk  = 1'b0;
  logic        vga_hs   = 1'b0;
  logic        vga_vs   = 1'b0;
  logic [7:0]  vga_r    = 8'd0;
  logic [7:0]  vga_g    = 8'd0;
  logic [7:0]  vga_b    = 8'd0;
  logic        locked;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_start;
  logic [7:0]  frame_count;
  logic [7:0]  err_count;
  logic [1:0]  err_code;

  vga_rx_monitor #(
    .H_TOTAL(H), .HS_WIDTH(HSW), .V_TOTAL(V), .VS_WIDTH(VSW),
    .H_ACT_MIN(HA), .V_ACT_MIN(VA)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .vga_clk(vga_clk),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_start(frame_start), .frame_count(frame_count),
    .err_count(err_count), .err_code(err_code)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_strobe = 0;
  int          fs_seen  = 0;
  logic [43:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected pixel.
  always @(negedge CLOCK_50) begin
    if (frame_start) fs_seen++;
    if (pix_valid) begin
      n_strobe++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got x=%0d y=%0d rgb=%06h, required no strobe",
                 pix_x, pix_y, pix_rgb);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        if ({pix_x, pix_y, pix_rgb} !== e) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%06h, required x=%0d y=%0d rgb=%06h",
                   pix_x, pix_y, pix_rgb, e[43:34], e[33:24], e[23:0]);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] colour(input int x, input int y);
    logic [7:0] s;
    if (x == 30 && y == 10) return 24'h993399;
    s = 8'(x + y);
    return {x[7:0], y[7:0], s};
  endfunction

  task automatic tick(input logic hs, input logic vs, input logic [23:0] c);
    @(posedge CLOCK_50); #1;
    vga_clk = 1'b1; vga_hs = hs; vga_vs = vs; {vga_r, vga_g, vga_b} = c;
    @(posedge CLOCK_50); #1;
    vga_clk = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_seg(input int v, input int i0, input int i1, input int hsw,
                           input bit vs, input bit lk);
    for (int i = i0; i < i1; i++) begin
      logic [23:0] c;
      c = colour(i, v);
      tick(i < hsw, vs, c);
      if (lk && i >= HA && v >= VA) exp_q.push_back({10'(i), 10'(v), c});
    end
  endtask

  task automatic frame(input int nlines, input int vsw, input int lk_lines,
                       input int sp_line, input int sp_len, input int sp_hsw);
    for (int v = 0; v < nlines; v++) begin
      if (v == sp_line) drive_seg(v, 0, sp_len, sp_hsw, v < vsw, v < lk_lines);
      else              drive_seg(v, 0, H, HSW, v < vsw, v < lk_lines);
    end
    settle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_locked"},      int'(locked),      0);
    check({tag, "_pix_valid"},   int'(pix_valid),   0);
    check({tag, "_pix_x"},       int'(pix_x),       0);
    check({tag, "_pix_y"},       int'(pix_y),       0);
    check({tag, "_pix_rgb"},     int'(pix_rgb),     0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_frame_count"}, int'(frame_count), 0);
    check({tag, "_err_count"},   int'(err_count),   0);
    check({tag, "_err_code"},    int'(err_code),    0);
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // Frame 1 enters CHECK; frame 2's VS rise locks.
    frame(V, VSW, 0, -1, H, HSW);
    check("locked_after_f1", int'(locked), 0);
    drive_seg(0, 0, 1, HSW, 1'b1, 1'b1);
    settle();
    check("locked_at_vs2", int'(locked), 1);
    check("fs_at_vs2", fs_seen, 1);
    drive_seg(0, 1, H, HSW, 1'b1, 1'b1);
    for (int v = 1; v < V; v++) drive_seg(v, 0, H, HSW, v < VSW, 1'b1);
    settle();

    // Frame 3: locked, includes 0x993399 at (30,10).
    s0 = n_strobe;
    frame(V, VSW, V, -1, H, HSW);
    check("strobes_per_frame", n_strobe - s0, (H - HA) * (V - VA));
    check("frame_start_pulses", fs_seen, 2);
    check("frame_count_f3", int'(frame_count), 2);
    check("err_count_f3", int'(err_count), 0);
    check("locked_f3", int'(locked), 1);

    // Frame 4: vga_clk stalls mid-line, then line 5 is one tick long.
    for (int v = 0; v < 4; v++) drive_seg(v, 0, H, HSW, v < VSW, 1'b1);
    drive_seg(4, 0, 20, HSW, 1'b0, 1'b1);
    repeat (1000) @(posedge CLOCK_50);
    #1;
    check("hold_pix_x", int'(pix_x), 19);
    check("hold_pix_y", int'(pix_y), 4);
    check("hold_locked", int'(locked), 1);
    check("hold_frame_count", int'(frame_count), 3);
    check("hold_err_count", int'(err_count), 0);
    drive_seg(4, 20, H, HSW, 1'b0, 1'b1);
    drive_seg(5, 0, H + 1, HSW, 1'b0, 1'b1);
    drive_seg(6, 0, 1, HSW, 1'b0, 1'b0);
    settle();
    check("long_line_code", int'(err_code), 0);
    check("long_line_count", int'(err_count), 1);
    check("long_line_locked", int'(locked), 0);
    drive_seg(6, 1, H, HSW, 1'b0, 1'b0);
    for (int v = 7; v < V; v++) drive_seg(v, 0, H, HSW, 1'b0, 1'b0);
    settle();

    // Re-lock after two clean VS rises.
    frame(V, VSW, 0, -1, H, HSW);
    check("relock_check_state", int'(locked), 0);
    frame(V, VSW, V, -1, H, HSW);
    check("relock_locked", int'(locked), 1);
    check("relock_err_count", int'(err_count), 1);

    // Short frame of 15 lines: error reported at the following VS rise.
    frame(V - 1, VSW, V, -1, H, HSW);
    check("frame_count_f7", int'(frame_count), 5);
    drive_seg(0, 0, 1, HSW, 1'b1, 1'b0);
    settle();
    check("short_frame_code", int'(err_code), 2);
    check("short_frame_count", int'(err_count), 2);
    check("short_frame_locked", int'(locked), 0);
    drive_seg(0, 1, H, HSW, 1'b1, 1'b0);
    for (int v = 1; v < V; v++) drive_seg(v, 0, H, HSW, v < VSW, 1'b0);

    // HS width 3 while in CHECK.
    frame(V, VSW, 0, 2, H, HSW - 1);
    check("hs_width_code", int'(err_code), 1);
    check("hs_width_count", int'(err_count), 3);
    check("hs_width_locked", int'(locked), 0);

    // VS width 4 while in CHECK.
    frame(V, VSW + 1, 0, -1, H, HSW);
    check("vs_width_code", int'(err_code), 3);
    check("vs_width_count", int'(err_count), 4);

    // Lock again, then reset mid-frame.
    frame(V, VSW, 0, -1, H, HSW);
    for (int v = 0; v < 6; v++) drive_seg(v, 0, H, HSW, v < VSW, 1'b1);
    settle();
    check("prereset_locked", int'(locked), 1);
    check("prereset_pix_y", int'(pix_y), 5);
    #3;
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check_reset_values("midrst");
    reset = 1'b0;

    // 300 bad HS pulses, each caught right after entering CHECK.
    for (int k = 0; k < 300; k++) begin
      tick(1'b1, 1'b1, 24'd0);
      tick(1'b0, 1'b1, 24'd0);
      tick(1'b0, 1'b0, 24'd0);
    end
    settle();
    check("sat_err_count", int'(err_count), 255);
    check("sat_err_code", int'(err_code), 1);
    check("sat_locked", int'(locked), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
